priority_scan_display: RTL and testbench
========================================

PRIORITY_SCAN_DISPLAY -- requirements
Module: priority_scan_display

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of data inputs, legal range 2..99.
REQ-002 SHALL have parameter SCAN_DIV, default 1024: clock cycles per displayed digit, legal range 2..65535.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 gives the highest set bit priority, 0 gives the lowest set bit priority.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port data, input, WIDTH: request bits.
REQ-007 SHALL have port capture_mode, input, 1: 0 = live, 1 = capture.
REQ-008 SHALL have port capture, input, 1: capture strobe, sampled every cycle.
REQ-009 SHALL have port clear, input, 1: return the result to the no-data state.
REQ-010 SHALL have port index, output, 7: registered binary index of the winning bit.
REQ-011 SHALL have port none, output, 1: registered flag, high when the result holds no set bit.
REQ-012 SHALL have port changed, output, 1: one-cycle pulse on any change of {none, index}.
REQ-013 SHALL have port segments, output, 7: gfedcba pattern, active-high.
REQ-014 SHALL have port dp, output, 1: decimal point, active-high.
REQ-015 SHALL have port digit_sel, output, 2: one-hot digit enable; 01 = ones digit, 10 = tens digit.

Function
REQ-016 SHALL register data into data_q every cycle.
REQ-017 SHALL compute the winning index and a found flag combinationally from data_q, using the MSB_FIRST priority.
REQ-018 In live mode, SHALL load the result register {none, index} every cycle; latency from data to index/none is 2 cycles.
REQ-019 In capture mode, SHALL load the result register only in cycles where capture=1, and hold it otherwise.
REQ-020 When clear=1, SHALL load none=1, index=0 next cycle in either mode; clear SHALL win over capture and over a live update in the same cycle.
REQ-021 A change of capture_mode SHALL take effect in the same cycle (no lost or duplicated update); live->capture holds the last loaded value.
REQ-022 SHALL assert changed for exactly one cycle, in the cycle after the result register takes a value different from its previous value.
REQ-023 changed SHALL NOT be asserted when the reloaded value is identical to the previous value.
REQ-024 SHALL run a scan counter 0..SCAN_DIV-1; on wrap to 0, digit_sel SHALL toggle between 01 and 10.
REQ-025 segments SHALL show the decimal ones digit of index when digit_sel=01, and the tens digit when digit_sel=10.
REQ-026 SHALL blank the tens digit (segments=0) when index<10.
REQ-027 When none=1, segments SHALL be 0 on both digits, and dp SHALL be 1 only while digit_sel=01.
REQ-028 When none=0, dp SHALL be 0.
REQ-029 Digit patterns (gfedcba) SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-030 segments, dp and digit_sel SHALL be registered, and SHALL update together one cycle after their inputs change.

Reset
REQ-031 On rst=1 at a clock edge, SHALL set: data_q=0, none=1, index=0, changed=0, scan counter=0, digit_sel=01, segments=0, dp=1.
REQ-032 rst SHALL override clear, capture and any scan in progress; capture_mode SHALL have no stored state.

Structure
REQ-033 SHALL place in package priority_display_pkg: the digit-pattern constant table, the digit_sel encodings (DIG_ONES, DIG_TENS), and the index width constant (7).
REQ-034 SHALL instantiate one sub-module, seg7_decoder: 4-bit BCD in, 7-bit gfedcba out, with blank for any value above 9.
REQ-035 Binary-to-BCD conversion of index SHALL be combinational; no divider IP shall be used.

Verification
REQ-036 WIDTH=16, live mode, data=0x0104 -> index=8, none=0 two cycles later, changed pulse once; ones digit=1111111, tens digit blank.
REQ-037 WIDTH=16, MSB_FIRST=0, data=0x0104 -> index=2, segments=1011011 on the ones digit.
REQ-038 Capture mode, data=0x8000, capture pulse, then data=0x0001 -> index stays 15 and no further changed pulse; display shows tens=0000110, ones=1101101.
REQ-039 data=0 in live mode -> none=1, segments=0, dp=1 only while digit_sel=01; capture and clear in the same cycle -> result is none.
REQ-040 SCAN_DIV=4 -> digit_sel toggles every 4 cycles; assert rst mid-scan -> all outputs match REQ-031 on the next cycle.

Source files
------------

// File: rtl/priority_display_pkg.sv
// Shared definitions for the priority scan display: digit patterns,
// digit-enable encodings, result index width and the binary-to-BCD helper.
package priority_display_pkg;

    localparam int IDX_W = 7;

    typedef enum logic [1:0] {
        DIG_ONES = 2'b01,
        DIG_TENS = 2'b10
    } dig_sel_e;

    // gfedcba, active-high; entry n holds the pattern for digit n
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
        7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    // Repeated subtraction; the index never exceeds 98, so a handful of steps covers it
    function automatic logic [7:0] bin_to_bcd(input logic [IDX_W-1:0] bin);
        logic [3:0]       tens;
        logic [IDX_W-1:0] rem;
        tens = '0;
        rem  = bin;
        for (int i = 0; i < 12; i++) begin
            if (rem >= IDX_W'(10)) begin
                rem  = rem - IDX_W'(10);
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to gfedcba seven-segment pattern; any code above 9 blanks the digit.
module seg7_decoder
    import priority_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = '0;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/priority_scan_display.sv
// Priority encoder over registered request bits with live/capture result register,
// change pulse, and a two-digit multiplexed seven-segment readout of the index.
module priority_scan_display
    import priority_display_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SCAN_DIV  = 1024,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             capture_mode,
    input  logic             capture,
    input  logic             clear,
    output logic [IDX_W-1:0] index,
    output logic             none,
    output logic             changed,
    output logic [6:0]       segments,
    output logic             dp,
    output logic [1:0]       digit_sel
);

    logic [WIDTH-1:0] r_data_q;
    logic [IDX_W-1:0] r_index;
    logic             r_none;
    logic             r_changed;
    logic [15:0]      r_scan_cnt;
    dig_sel_e         r_digit_sel;
    logic [6:0]       r_segments;
    logic             r_dp;

    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_next_none;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_scan_wrap;
    dig_sel_e         w_sel_next;
    logic [7:0]       w_bcd;
    logic             w_blank;
    logic [3:0]       w_dec_in;
    logic [6:0]       w_seg;

    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (r_data_q[i]) begin
                    w_found   = 1'b1;
                    w_win_idx = IDX_W'(i);
                end
            end else if (r_data_q[WIDTH-1-i]) begin
                w_found   = 1'b1;
                w_win_idx = IDX_W'(WIDTH-1-i);
            end
        end
    end

    // Clear beats both capture and live loading; capture_mode acts combinationally
    always_comb begin
        w_next_none = r_none;
        w_next_idx  = r_index;
        if (clear) begin
            w_next_none = 1'b1;
            w_next_idx  = '0;
        end else if (!capture_mode || capture) begin
            w_next_none = !w_found;
            w_next_idx  = w_win_idx;
        end
    end

    assign w_scan_wrap = (r_scan_cnt == 16'(SCAN_DIV - 1));

    always_comb begin
        w_sel_next = r_digit_sel;
        if (w_scan_wrap) begin
            w_sel_next = (r_digit_sel == DIG_ONES) ? DIG_TENS : DIG_ONES;
        end
    end

    // Display registers are built from the digit about to be enabled so they move together
    assign w_bcd    = bin_to_bcd(r_index);
    assign w_blank  = r_none || ((w_sel_next == DIG_TENS) && (w_bcd[7:4] == 4'd0));
    assign w_dec_in = w_blank ? 4'hF : ((w_sel_next == DIG_ONES) ? w_bcd[3:0] : w_bcd[7:4]);

    seg7_decoder u_seg7_decoder (
        .i_bcd (w_dec_in),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q    <= '0;
            r_none      <= 1'b1;
            r_index     <= '0;
            r_changed   <= 1'b0;
            r_scan_cnt  <= '0;
            r_digit_sel <= DIG_ONES;
            r_segments  <= '0;
            r_dp        <= 1'b1;
        end else begin
            r_data_q    <= data;
            r_none      <= w_next_none;
            r_index     <= w_next_idx;
            r_changed   <= ({w_next_none, w_next_idx} != {r_none, r_index});
            r_scan_cnt  <= w_scan_wrap ? 16'd0 : r_scan_cnt + 16'd1;
            r_digit_sel <= w_sel_next;
            r_segments  <= w_seg;
            r_dp        <= r_none && (w_sel_next == DIG_ONES);
        end
    end

    assign index     = r_index;
    assign none      = r_none;
    assign changed   = r_changed;
    assign segments  = r_segments;
    assign dp        = r_dp;
    assign digit_sel = r_digit_sel;

endmodule

// File: tb/tb_priority_scan_display.sv
// Scoreboard bench: two configurations driven in lockstep, checked against a behavioural model.
module tb_priority_scan_display;

    logic        clk;
    logic        rst;
    logic [15:0] data_a;
    logic [69:0] data_b;
    logic        capture_mode;
    logic        capture;
    logic        clear;

    logic [6:0] idx_a, idx_b, seg_a, seg_b;
    logic       none_a, none_b, chg_a, chg_b, dp_a, dp_b;
    logic [1:0] sel_a, sel_b;

    priority_scan_display #(.WIDTH(16), .SCAN_DIV(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .data(data_a), .capture_mode(capture_mode),
        .capture(capture), .clear(clear), .index(idx_a), .none(none_a),
        .changed(chg_a), .segments(seg_a), .dp(dp_a), .digit_sel(sel_a)
    );

    priority_scan_display #(.WIDTH(70), .SCAN_DIV(5), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .data(data_b), .capture_mode(capture_mode),
        .capture(capture), .clear(clear), .index(idx_b), .none(none_b),
        .changed(chg_b), .segments(seg_b), .dp(dp_b), .digit_sel(sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] idx;
        logic       none;
        logic       chg;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] sel;
    } exp_t;

    exp_t       cyc_q_a[$];
    exp_t       cyc_q_b[$];
    logic [7:0] evt_q_a[$];
    logic [7:0] evt_q_b[$];

    int checks   = 0;
    int failures = 0;

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    int m_width [2] = '{16, 70};
    int m_div   [2] = '{4, 5};
    bit m_msb   [2] = '{1'b1, 1'b0};

    logic [127:0] m_dq [2];
    int           m_idx  [2];
    bit           m_none [2];
    bit           m_chg  [2];
    int           m_cnt  [2];
    bit           m_ones [2];
    logic [6:0]   m_seg  [2];
    bit           m_dp   [2];

    function automatic int winner(logic [127:0] d, int w, bit msb);
        int best = -1;
        for (int i = 0; i < w; i++) begin
            if (d[i] && (msb || best < 0)) best = i;
        end
        return best;
    endfunction

    task automatic model_step(int k, bit r, logic [127:0] d, bit mode, bit cap, bit clr);
        int   w;
        bit   n_none, n_ones;
        int   n_idx, n_cnt;
        exp_t e;
        if (r) begin
            m_dq[k] = '0; m_none[k] = 1'b1; m_idx[k] = 0; m_chg[k] = 1'b0;
            m_cnt[k] = 0; m_ones[k] = 1'b1; m_seg[k] = '0; m_dp[k] = 1'b1;
        end else begin
            if (m_cnt[k] == m_div[k] - 1) begin
                n_cnt = 0; n_ones = !m_ones[k];
            end else begin
                n_cnt = m_cnt[k] + 1; n_ones = m_ones[k];
            end
            if (m_none[k])            m_seg[k] = '0;
            else if (n_ones)          m_seg[k] = pat[m_idx[k] % 10];
            else if (m_idx[k] < 10)   m_seg[k] = '0;
            else                      m_seg[k] = pat[m_idx[k] / 10];
            m_dp[k] = m_none[k] && n_ones;
            n_none = m_none[k];
            n_idx  = m_idx[k];
            if (clr) begin
                n_none = 1'b1; n_idx = 0;
            end else if (!mode || cap) begin
                w = winner(m_dq[k], m_width[k], m_msb[k]);
                n_none = (w < 0);
                n_idx  = (w < 0) ? 0 : w;
            end
            m_chg[k]  = (n_none != m_none[k]) || (n_idx != m_idx[k]);
            m_none[k] = n_none;
            m_idx[k]  = n_idx;
            m_cnt[k]  = n_cnt;
            m_ones[k] = n_ones;
            m_dq[k]   = d;
        end
        e.idx  = 7'(m_idx[k]);
        e.none = m_none[k];
        e.chg  = m_chg[k];
        e.seg  = m_seg[k];
        e.dp   = m_dp[k];
        e.sel  = m_ones[k] ? 2'b01 : 2'b10;
        if (k == 0) begin
            cyc_q_a.push_back(e);
            if (m_chg[k]) evt_q_a.push_back({m_none[k], 7'(m_idx[k])});
        end else begin
            cyc_q_b.push_back(e);
            if (m_chg[k]) evt_q_b.push_back({m_none[k], 7'(m_idx[k])});
        end
    endtask

    task automatic cmp(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_dut(int k, logic [6:0] idx, logic none, logic chg,
                             logic [6:0] seg, logic dp, logic [1:0] sel);
        exp_t       e;
        logic [7:0] ev;
        bit         have_e, have_ev;
        have_e = (k == 0) ? (cyc_q_a.size() > 0) : (cyc_q_b.size() > 0);
        if (have_e) begin
            if (k == 0) e = cyc_q_a.pop_front();
            else        e = cyc_q_b.pop_front();
            cmp("index", k, 32'(idx), 32'(e.idx));
            cmp("none", k, 32'(none), 32'(e.none));
            cmp("changed", k, 32'(chg), 32'(e.chg));
            cmp("segments", k, 32'(seg), 32'(e.seg));
            cmp("dp", k, 32'(dp), 32'(e.dp));
            cmp("digit_sel", k, 32'(sel), 32'(e.sel));
        end
        if (chg === 1'b1) begin
            have_ev = (k == 0) ? (evt_q_a.size() > 0) : (evt_q_b.size() > 0);
            if (!have_ev) begin
                checks++;
                failures++;
                $display("FAIL change_event dut%0d: got pulse expected none pending at %0t", k, $time);
            end else begin
                if (k == 0) ev = evt_q_a.pop_front();
                else        ev = evt_q_b.pop_front();
                cmp("change_value", k, 32'({none, idx}), 32'(ev));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut(0, idx_a, none_a, chg_a, seg_a, dp_a, sel_a);
            check_dut(1, idx_b, none_b, chg_b, seg_b, dp_b, sel_b);
        end
    end

    task automatic drive(bit r, logic [15:0] da, logic [69:0] db, bit mode, bit cap, bit clr);
        rst = r; data_a = da; data_b = db;
        capture_mode = mode; capture = cap; clear = clr;
        model_step(0, r, 128'(da), mode, cap, clr);
        model_step(1, r, 128'(db), mode, cap, clr);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] gen_a();
        case ($urandom_range(0, 3))
            0:       return 16'h0;
            1:       return 16'h1 << $urandom_range(0, 15);
            default: return 16'($urandom) & 16'($urandom);
        endcase
    endfunction

    function automatic logic [69:0] gen_b();
        logic [69:0] v;
        case ($urandom_range(0, 3))
            0:       v = '0;
            1:       v = 70'h1 << $urandom_range(0, 69);
            2:       v = (70'h1 << $urandom_range(0, 69)) | (70'h1 << $urandom_range(0, 69));
            default: v = 70'({$urandom, $urandom, $urandom}) & 70'({$urandom, $urandom, $urandom})
                         & 70'({$urandom, $urandom, $urandom});
        endcase
        return v;
    endfunction

    initial begin
        bit          mode, cap, clr, r;
        logic [15:0] da;
        logic [69:0] db;

        repeat (3) drive(1, 16'h0, '0, 0, 0, 0);
        cmp("reset_none", 0, 32'(none_a), 32'd1);
        cmp("reset_dp", 0, 32'(dp_a), 32'd1);

        // live priority, two-cycle latency
        repeat (2) drive(0, 16'h0104, 70'h104, 0, 0, 0);
        cmp("live_index_msb", 0, 32'(idx_a), 32'd8);
        cmp("live_index_lsb", 1, 32'(idx_b), 32'd2);
        cmp("live_pulse", 0, 32'(chg_a), 32'd1);
        repeat (10) drive(0, 16'h0104, 70'h104, 0, 0, 0);

        repeat (12) drive(0, 16'h0, '0, 0, 0, 0);
        cmp("empty_none", 0, 32'(none_a), 32'd1);

        // capture holds across new data
        drive(0, 16'h8000, 70'h1 << 45, 1, 0, 0);
        drive(0, 16'h0001, 70'h1, 1, 1, 0);
        repeat (16) drive(0, 16'h0001, 70'h1, 1, 0, 0);
        cmp("capture_hold_a", 0, 32'(idx_a), 32'd15);
        cmp("capture_hold_b", 1, 32'(idx_b), 32'd45);

        drive(0, 16'h00F0, 70'hF0, 1, 1, 1);
        cmp("clear_beats_capture", 0, 32'(none_a), 32'd1);
        repeat (3) drive(0, 16'h00F0, 70'hF0, 1, 0, 0);

        repeat (4) drive(0, 16'h0420, 70'h1 << 67, 0, 0, 0);
        drive(0, 16'h0002, 70'h2, 1, 0, 0);
        repeat (5) drive(0, 16'h0002, 70'h2, 1, 0, 0);
        cmp("live_to_capture_hold", 0, 32'(idx_a), 32'd10);

        repeat (6) drive(0, 16'h4000, 70'h1 << 38, 0, 0, 0);
        drive(1, 16'h4000, 70'h1 << 38, 0, 1, 1);
        cmp("midscan_rst_sel", 0, 32'(sel_a), 32'd1);
        cmp("midscan_rst_seg", 0, 32'(seg_a), 32'd0);
        cmp("midscan_rst_index", 0, 32'(idx_a), 32'd0);
        cmp("midscan_rst_changed", 0, 32'(chg_a), 32'd0);

        mode = 0;
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 19) == 0) mode = !mode;
            cap = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 24) == 0);
            r   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 2) != 0) begin
                da = gen_a();
                db = gen_b();
            end
            drive(r, da, db, mode, cap, clr);
        end

        @(negedge clk);
        #1;
        cmp("cycle_queue_a_drained", 0, 32'(cyc_q_a.size()), 32'd0);
        cmp("cycle_queue_b_drained", 1, 32'(cyc_q_b.size()), 32'd0);
        cmp("event_queue_a_drained", 0, 32'(evt_q_a.size()), 32'd0);
        cmp("event_queue_b_drained", 1, 32'(evt_q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
